// File: rtl/am_port_arbiter.sv
// Two-port arbiter for the AM SRAM (encoder vs external/DMA) with burst lock.
// Optional ext starvation guard: define AM_ARB_STARVE_PROTECT_EN.
module am_port_arbiter #(
    parameter int HV_LENGTH     = 2048,
    parameter int AM_ADDR_WIDTH = 13,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic                     enc_req_valid_i,
    output logic                     enc_req_ready_o,
    input  logic                     enc_we_i,
    input  logic                     enc_lock_i,
    input  logic [AM_ADDR_WIDTH-1:0] enc_addr_i,
    input  logic [HV_LENGTH-1:0]     enc_wdata_i,
    output logic                     enc_rsp_valid_o,
    output logic [HV_LENGTH-1:0]     enc_rdata_o,

    input  logic                     ext_req_valid_i,
    output logic                     ext_req_ready_o,
    input  logic                     ext_we_i,
    input  logic                     ext_lock_i,
    input  logic [AM_ADDR_WIDTH-1:0] ext_addr_i,
    input  logic [HV_LENGTH-1:0]     ext_wdata_i,
    output logic                     ext_rsp_valid_o,
    output logic [HV_LENGTH-1:0]     ext_rdata_o,

    output logic [AM_ADDR_WIDTH-1:0] sram_addr_o,
    output logic                     sram_wen_o,
    output logic                     sram_ren_o,
    output logic [HV_LENGTH-1:0]     sram_wdata_o,
    input  logic [HV_LENGTH-1:0]     sram_rdata_i
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] OWN_ENC = 2'd1;
    localparam logic [1:0] OWN_EXT = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       trigger;
    logic       grant_enc;
    logic       grant_ext;
    logic       enc_pend_q;
    logic       ext_pend_q;

`ifdef AM_ARB_STARVE_PROTECT_EN
    logic [7:0] starve_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= 8'd0;
        end else if (grant_ext) begin
            starve_q <= 8'd0;
        end else if (ext_req_valid_i && (starve_q != 8'hFF)) begin
            starve_q <= starve_q + 8'd1;
        end
    end

    assign trigger = (starve_q >= 8'(STARVE_LIMIT));
`else
    assign trigger = 1'b0;
`endif

    // Grants are gated by reset so every output is 0 while rst_ni is low.
    always_comb begin
        grant_enc = 1'b0;
        grant_ext = 1'b0;
        if (rst_ni) begin
            case (state_q)
                IDLE: begin
                    if (enc_req_valid_i && !trigger) begin
                        grant_enc = 1'b1;
                    end else if (ext_req_valid_i) begin
                        grant_ext = 1'b1;
                    end
                end
                OWN_ENC: grant_enc = enc_req_valid_i;
                OWN_EXT: grant_ext = ext_req_valid_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        if (grant_enc) begin
            state_d = enc_lock_i ? OWN_ENC : IDLE;
        end else if (grant_ext) begin
            state_d = ext_lock_i ? OWN_EXT : IDLE;
        end else if (state_q == 2'd3) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            enc_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            enc_pend_q <= grant_enc && !enc_we_i;
            ext_pend_q <= grant_ext && !ext_we_i;
        end
    end

    assign enc_req_ready_o = grant_enc;
    assign ext_req_ready_o = grant_ext;

    always_comb begin
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_wen_o   = 1'b0;
        sram_ren_o   = 1'b0;
        unique case (1'b1)
            grant_enc: begin
                sram_addr_o  = enc_addr_i;
                sram_wdata_o = enc_wdata_i;
                sram_wen_o   = enc_we_i;
                sram_ren_o   = !enc_we_i;
            end
            grant_ext: begin
                sram_addr_o  = ext_addr_i;
                sram_wdata_o = ext_wdata_i;
                sram_wen_o   = ext_we_i;
                sram_ren_o   = !ext_we_i;
            end
            default: ;
        endcase
    end

    assign enc_rsp_valid_o = enc_pend_q;
    assign ext_rsp_valid_o = ext_pend_q;
    assign enc_rdata_o     = enc_pend_q ? sram_rdata_i : '0;
    assign ext_rdata_o     = ext_pend_q ? sram_rdata_i : '0;

endmodule

// File: tb/tb_am_port_arbiter.sv
// Randomized scoreboard bench for am_port_arbiter.
// Reference model tracks owner, starvation count and memory contents.
module tb_am_port_arbiter;

    localparam int HV = 64;
    localparam int AW = 13;
    localparam int SL = 8;

    logic          clk;
    logic          rst_ni;
    logic          enc_req_valid_i, enc_we_i, enc_lock_i;
    logic [AW-1:0] enc_addr_i;
    logic [HV-1:0] enc_wdata_i;
    logic          ext_req_valid_i, ext_we_i, ext_lock_i;
    logic [AW-1:0] ext_addr_i;
    logic [HV-1:0] ext_wdata_i;
    logic          enc_req_ready_o, ext_req_ready_o;
    logic          enc_rsp_valid_o, ext_rsp_valid_o;
    logic [HV-1:0] enc_rdata_o, ext_rdata_o;
    logic [AW-1:0] sram_addr_o;
    logic          sram_wen_o, sram_ren_o;
    logic [HV-1:0] sram_wdata_o;
    logic [HV-1:0] sram_rdata_i;

    am_port_arbiter #(
        .HV_LENGTH(HV), .AM_ADDR_WIDTH(AW), .STARVE_LIMIT(SL)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .enc_req_valid_i(enc_req_valid_i), .enc_req_ready_o(enc_req_ready_o),
        .enc_we_i(enc_we_i), .enc_lock_i(enc_lock_i),
        .enc_addr_i(enc_addr_i), .enc_wdata_i(enc_wdata_i),
        .enc_rsp_valid_o(enc_rsp_valid_o), .enc_rdata_o(enc_rdata_o),
        .ext_req_valid_i(ext_req_valid_i), .ext_req_ready_o(ext_req_ready_o),
        .ext_we_i(ext_we_i), .ext_lock_i(ext_lock_i),
        .ext_addr_i(ext_addr_i), .ext_wdata_i(ext_wdata_i),
        .ext_rsp_valid_o(ext_rsp_valid_o), .ext_rdata_o(ext_rdata_o),
        .sram_addr_o(sram_addr_o), .sram_wen_o(sram_wen_o),
        .sram_ren_o(sram_ren_o), .sram_wdata_o(sram_wdata_o),
        .sram_rdata_i(sram_rdata_i)
    );

    typedef struct {
        logic [HV-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          enc_q[$];
    rsp_t          ext_q[$];
    logic [HV-1:0] ref_mem  [0:8191];
    logic [HV-1:0] sram_mem [0:8191];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            m_owner = 0;
    int            m_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment SRAM with one cycle read latency.
    always @(posedge clk) begin
        if (sram_ren_o) sram_rdata_i <= sram_mem[sram_addr_o];
        if (sram_wen_o) sram_mem[sram_addr_o] <= sram_wdata_o;
    end

    function automatic void chk(string name, logic [HV-1:0] act,
                                logic [HV-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) a = a ^ 13'h1FF0;
        return a;
    endfunction

    task automatic check_outputs_zero(string tag);
        chk({tag, "_enc_ready"}, HV'(enc_req_ready_o), '0);
        chk({tag, "_ext_ready"}, HV'(ext_req_ready_o), '0);
        chk({tag, "_enc_rsp"}, HV'(enc_rsp_valid_o), '0);
        chk({tag, "_ext_rsp"}, HV'(ext_rsp_valid_o), '0);
        chk({tag, "_enc_rdata"}, enc_rdata_o, '0);
        chk({tag, "_ext_rdata"}, ext_rdata_o, '0);
        chk({tag, "_sram_ctl"}, HV'({sram_wen_o, sram_ren_o}), '0);
        chk({tag, "_sram_addr"}, HV'(sram_addr_o), '0);
        chk({tag, "_sram_wdata"}, sram_wdata_o, '0);
    endtask

    task automatic drive_idle();
        enc_req_valid_i = 0; enc_we_i = 0; enc_lock_i = 0;
        enc_addr_i = '0; enc_wdata_i = '0;
        ext_req_valid_i = 0; ext_we_i = 0; ext_lock_i = 0;
        ext_addr_i = '0; ext_wdata_i = '0;
    endtask

    // One cycle: drive at negedge, check combinational outputs, advance model.
    task automatic step(input bit ev, input bit ew, input bit el,
                        input logic [AW-1:0] ea, input logic [HV-1:0] ed,
                        input bit xv, input bit xw, input bit xl,
                        input logic [AW-1:0] xa, input logic [HV-1:0] xd,
                        input int exp_g);
        int g;
        bit trig;
        rsp_t r;
        @(negedge clk);
        enc_req_valid_i = ev; enc_we_i = ew; enc_lock_i = el;
        enc_addr_i = ea; enc_wdata_i = ed;
        ext_req_valid_i = xv; ext_we_i = xw; ext_lock_i = xl;
        ext_addr_i = xa; ext_wdata_i = xd;
        #1;
`ifdef AM_ARB_STARVE_PROTECT_EN
        trig = (m_cnt >= SL);
`else
        trig = 1'b0;
`endif
        g = 0;
        if (m_owner == 1) g = ev ? 1 : 0;
        else if (m_owner == 2) g = xv ? 2 : 0;
        else if (ev && !trig) g = 1;
        else if (xv) g = 2;
        chk("enc_ready", HV'(enc_req_ready_o), HV'(g == 1));
        chk("ext_ready", HV'(ext_req_ready_o), HV'(g == 2));
        if (exp_g >= 0)
            chk("directed_grant", HV'({enc_req_ready_o, ext_req_ready_o}),
                HV'({exp_g == 1, exp_g == 2}));
        if (g == 0) begin
            chk("sram_ctl_idle", HV'({sram_wen_o, sram_ren_o}), '0);
            chk("sram_addr_idle", HV'(sram_addr_o), '0);
            chk("sram_wdata_idle", sram_wdata_o, '0);
        end else begin
            chk("sram_addr", HV'(sram_addr_o), HV'(g == 1 ? ea : xa));
            chk("sram_wdata", sram_wdata_o, g == 1 ? ed : xd);
            chk("sram_ctl", HV'({sram_wen_o, sram_ren_o}),
                HV'(g == 1 ? {ew, !ew} : {xw, !xw}));
        end
        if (g == 1) begin
            if (ew) ref_mem[ea] = ed;
            else begin
                r.data = ref_mem[ea]; r.due = cyc + 1; enc_q.push_back(r);
            end
            m_owner = el ? 1 : 0;
        end else if (g == 2) begin
            if (xw) ref_mem[xa] = xd;
            else begin
                r.data = ref_mem[xa]; r.due = cyc + 1; ext_q.push_back(r);
            end
            m_owner = xl ? 2 : 0;
        end
        if (g == 2) m_cnt = 0;
        else if (xv && m_cnt < 255) m_cnt++;
    endtask

    task automatic hold_reset_checks(string tag);
        enc_req_valid_i = 1; ext_req_valid_i = 1;
        enc_addr_i = 13'h5; ext_addr_i = 13'h10;
        enc_wdata_i = 64'hDEAD; ext_wdata_i = 64'hBEEF;
        #1;
        check_outputs_zero(tag);
        drive_idle();
        enc_q.delete(); ext_q.delete();
        m_owner = 0; m_cnt = 0;
    endtask

    // Response monitor: pops the scoreboard whenever a pulse appears.
    task automatic mon_port(string nm, logic v, logic [HV-1:0] d,
                            ref rsp_t q[$]);
        rsp_t r;
        if (v) begin
            if (q.size() == 0) begin
                chk({nm, "_spurious_rsp"}, HV'(v), '0);
            end else begin
                r = q.pop_front();
                chk({nm, "_rdata"}, d, r.data);
                chk({nm, "_rsp_cycle"}, HV'(cyc), HV'(r.due));
            end
        end else begin
            chk({nm, "_rdata_zero"}, d, '0);
            if (q.size() != 0 && q[0].due <= cyc) begin
                r = q.pop_front();
                chk({nm, "_missing_rsp"}, HV'(v), 1);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                mon_port("enc", enc_rsp_valid_o, enc_rdata_o, enc_q);
                mon_port("ext", ext_rsp_valid_o, ext_rdata_o, ext_q);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        for (int i = 0; i < 8192; i++) begin
            ref_mem[i] = '0;
            sram_mem[i] = '0;
        end
        sram_rdata_i = '0;
        drive_idle();
        rst_ni = 1'b0;
        #3;
        hold_reset_checks("reset");
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // Seed rows used by the directed reads.
        step(1, 1, 0, 13'h005, 64'hA5A5_0005_1234_5678, 0, 0, 0, '0, '0, 1);
        step(1, 1, 0, 13'h1FF, 64'h0FF1_CE00_CAFE_01FF, 0, 0, 0, '0, '0, 1);

        // Both valid: enc read wins, ext write follows.
        step(1, 0, 0, 13'h005, '0, 1, 1, 0, 13'h010, 64'h1010, 1);
        step(0, 0, 0, '0, '0, 1, 1, 0, 13'h010, 64'h1010, 2);

        // Lone ext read.
        step(0, 0, 0, '0, '0, 1, 0, 0, 13'h1FF, '0, 2);
        step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);

        // Locked enc burst holds off ext.
        step(1, 1, 1, 13'h020, 64'h21, 1, 0, 0, 13'h005, '0, 1);
        step(1, 1, 1, 13'h021, 64'h22, 1, 0, 0, 13'h005, '0, 1);
        step(1, 1, 1, 13'h022, 64'h23, 1, 0, 0, 13'h005, '0, 1);
        step(1, 1, 0, 13'h023, 64'h24, 1, 0, 0, 13'h005, '0, 1);
        step(0, 0, 0, '0, '0, 1, 0, 0, 13'h005, '0, 2);

        // Continuous unlocked enc traffic against a waiting ext.
        for (int i = 1; i <= 12; i++) begin
`ifdef AM_ARB_STARVE_PROTECT_EN
            step(1, 1, 0, 13'h030, HV'(i), 1, 0, 0, 13'h020, '0,
                 (i == 9) ? 2 : 1);
`else
            step(1, 1, 0, 13'h030, HV'(i), 1, 0, 0, 13'h020, '0, 1);
`endif
        end
        step(0, 0, 0, '0, '0, 1, 0, 0, 13'h020, '0, 2);

        // Alternating reads, one per cycle.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                step(1, 0, 0, 13'(32 + i / 2), '0, 0, 0, 0, '0, '0, 1);
            else
                step(0, 0, 0, '0, '0, 1, 0, 0, 13'(33 - i / 2), '0, 2);
        end
        step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0);

        // Reset lands while an enc read is in flight.
        step(1, 0, 0, 13'h005, '0, 0, 0, 0, '0, '0, 1);
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        hold_reset_checks("async_reset");
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        step(0, 0, 0, '0, '0, 1, 0, 0, 13'h1FF, '0, 2);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4) == 0, rand_addr(), {$urandom, $urandom},
                 $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4) == 0, rand_addr(), {$urandom, $urandom},
                 -1);
        end

        repeat (3) step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, -1);
        @(negedge clk);
        #2;
        chk("enc_q_drained", HV'(enc_q.size()), '0);
        chk("ext_q_drained", HV'(ext_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/am_port_arbiter.md
AM_PORT_ARBITER -- requirements
Module: am_port_arbiter

Interface
REQ-001 Parameter HV_LENGTH, default 2048: AM row/data width in bits.
REQ-002 Parameter AM_ADDR_WIDTH, default 13: AM address width.
REQ-003 Parameter STARVE_LIMIT, default 8: consecutive lost ext cycles before ext is forced to win; range 1..255.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 enc_req_valid_i / ext_req_valid_i  in  1  request present from the encoder or the external (DMA) port.
REQ-007 enc_req_ready_o / ext_req_ready_o  out  1  request accepted this cycle.
REQ-008 enc_we_i / ext_we_i  in  1  1 = write, 0 = read.
REQ-009 enc_lock_i / ext_lock_i  in  1  keep ownership after this beat (burst).
REQ-010 enc_addr_i / ext_addr_i  in  AM_ADDR_WIDTH  row address.
REQ-011 enc_wdata_i / ext_wdata_i  in  HV_LENGTH  write data.
REQ-012 enc_rsp_valid_o / ext_rsp_valid_o  out  1  read data valid, single-cycle pulse.
REQ-013 enc_rdata_o / ext_rdata_o  out  HV_LENGTH  read data.
REQ-014 sram_addr_o  out  AM_ADDR_WIDTH, sram_wen_o  out  1, sram_ren_o  out  1, sram_wdata_o  out  HV_LENGTH: AM port.
REQ-015 sram_rdata_i  in  HV_LENGTH  AM read data, valid the cycle after sram_ren_o.

Function
REQ-016 A beat transfers when req_valid and req_ready are both high on the same rising edge; ready is combinational from state and valid, and at most one ready is high per cycle.
REQ-017 The FSM has three states: IDLE, OWN_ENC, OWN_EXT.
REQ-018 In IDLE, ENC is granted if enc_req_valid_i is high and the starvation trigger is inactive; otherwise EXT is granted if ext_req_valid_i is high.
REQ-019 A granted beat with lock_i=1 moves the FSM to the corresponding OWN state; a beat with lock_i=0 moves it, or keeps it, in IDLE.
REQ-020 In OWN_x, only requester x is granted; other requests wait with ready=0. The FSM returns to IDLE after x transfers a beat with lock_i=0. An idle owner holds ownership indefinitely.
REQ-021 SRAM drive in a transfer cycle: sram_addr_o and sram_wdata_o come from the granted requester, sram_wen_o = we, sram_ren_o = !we. With no transfer, all SRAM outputs are 0.
REQ-022 Read latency is 1: x_rsp_valid_o is high exactly the cycle after x's read transfer, with x_rdata_o = sram_rdata_i. Otherwise x_rdata_o is 0. There is no response backpressure.
REQ-023 Back-to-back reads from either or both requesters are sustained at 1 beat/cycle; a response to one requester and a new transfer to the other may occur in the same cycle.
REQ-024 A write produces no response pulse.

Reset
REQ-025 Asynchronous assertion of rst_ni forces IDLE, clears the starvation counter and the pending-response flags, and drives all outputs to 0. Any read in flight is dropped with no response.
REQ-026 Outputs stay 0 until the first rising edge after deassertion; a request at that edge may be granted.

Configuration
REQ-027 Macro AM_ARB_STARVE_PROTECT_EN: when defined, an 8-bit saturating counter increments each cycle ext_req_valid_i=1 and ext_req_ready_o=0, and clears on an ext transfer. The starvation trigger is counter >= STARVE_LIMIT.
REQ-028 The trigger only affects IDLE arbitration; an OWN_ENC lock is never broken.
REQ-029 When AM_ARB_STARVE_PROTECT_EN is undefined, there is no counter, the trigger is constant 0, and ENC has fixed priority.

Verification
REQ-030 Both valid in IDLE, enc read addr 0x005, ext write addr 0x010 -> enc granted; sram_ren_o=1, addr 0x005; enc_rsp_valid_o pulses next cycle with rdata = sram_rdata_i; ext granted the following cycle.
REQ-031 ext read addr 0x1FF with enc idle -> ext_req_ready_o=1 same cycle; ext_rsp_valid_o exactly 1 cycle later; enc_rsp_valid_o stays 0.
REQ-032 enc bursts 4 writes with lock_i=1,1,1,0 while ext is valid -> 4 consecutive enc grants, ext ready=0 throughout; FSM returns to IDLE; ext granted next cycle.
REQ-033 With the macro defined, STARVE_LIMIT=8, enc valid unlocked continuously, ext valid -> ext granted on cycle 9. Without the macro, ext is never granted while enc is valid.
REQ-034 rst_ni asserted in the cycle after an enc read transfer -> no enc_rsp_valid_o pulse, FSM in IDLE, all outputs 0 immediately (asynchronous).
REQ-035 Alternating enc read / ext read every cycle for 6 cycles -> each response pulses on the correct port 1 cycle after its transfer, with no lost or misrouted data.
